// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline stage with valid/ready handshaking and a two-entry skid buffer.
// The main entry drives the execute-side outputs, and the skid entry absorbs one
// instruction under back-pressure. Flush kills every held entry synchronously.
module id_ex_pipe_stage #(
  parameter int unsigned OPCODE_W   = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned MEM_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  // Decode side
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPCODE_W-1:0]   opcode_in,
  input  logic [DATA_W-1:0]     operand1_in,
  input  logic [DATA_W-1:0]     operand2_in,
  input  logic [REG_ADDR_W-1:0] reg_addr_in,
  input  logic [MEM_ADDR_W-1:0] mem_addr_in,
  input  logic                  write_enable_in,
  input  logic                  store_enable_in,
  input  logic                  load_enable_in,
  // Execute side
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPCODE_W-1:0]   opcode_out,
  output logic [DATA_W-1:0]     operand1_out,
  output logic [DATA_W-1:0]     operand2_out,
  output logic [REG_ADDR_W-1:0] reg_addr_out,
  output logic [MEM_ADDR_W-1:0] mem_addr_out,
  output logic                  write_enable_out,
  output logic                  store_enable_out,
  output logic                  load_enable_out,
  output logic [1:0]            occupancy
);

  localparam int unsigned PayW = OPCODE_W + 2 * DATA_W + REG_ADDR_W + MEM_ADDR_W + 3;

  // Encoding is {main_valid, skid_valid}, so the valid bits fall straight out of the state.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StTwo   = 2'b11
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [PayW-1:0] r_main;
  logic [PayW-1:0] r_skid;
  logic [PayW-1:0] w_in_payload;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_accept;
  logic            w_issue;
  logic            w_main_ld_in;
  logic            w_main_ld_skid;
  logic            w_skid_ld;
  logic            w_main_we;
  logic            w_main_se;
  logic            w_main_le;

  assign w_in_payload = {opcode_in, operand1_in, operand2_in, reg_addr_in, mem_addr_in,
                         write_enable_in, store_enable_in, load_enable_in};

  // in_ready is taken from registered state only, so out_ready never reaches it combinationally.
  assign w_in_ready  = (r_state != StTwo);
  assign w_out_valid = r_state[1];
  assign w_accept    = in_valid & w_in_ready;
  assign w_issue     = w_out_valid & out_ready;

  // Next-state and entry-load decode; flush overrides every transition and capture.
  always_comb begin
    w_state_next   = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    unique case (r_state)
      StEmpty: begin
        if (w_accept) begin
          w_main_ld_in = 1'b1;
          w_state_next = StOne;
        end
      end
      StOne: begin
        if (w_accept && w_issue) begin
          w_main_ld_in = 1'b1;
        end else if (w_accept) begin
          w_skid_ld    = 1'b1;
          w_state_next = StTwo;
        end else if (w_issue) begin
          w_state_next = StEmpty;
        end
      end
      StTwo: begin
        // Skid never issues directly; it moves up into main to preserve order.
        if (w_issue) begin
          w_main_ld_skid = 1'b1;
          w_state_next   = StOne;
        end
      end
      default: w_state_next = StEmpty;
    endcase
    if (flush) begin
      w_state_next   = StEmpty;
      w_main_ld_in   = 1'b0;
      w_main_ld_skid = 1'b0;
      w_skid_ld      = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Main entry payload: loads from decode or is promoted from skid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
    end else if (w_main_ld_in) begin
      r_main <= w_in_payload;
    end else if (w_main_ld_skid) begin
      r_main <= r_skid;
    end
  end

  // Skid entry payload: captures only when main is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid <= '0;
    end else if (w_skid_ld) begin
      r_skid <= w_in_payload;
    end
  end

  assign {opcode_out, operand1_out, operand2_out, reg_addr_out, mem_addr_out,
          w_main_we, w_main_se, w_main_le} = r_main;

  // Gate the enables so that a bubble or killed slot cannot write, store or load.
  assign write_enable_out = w_main_we & w_out_valid;
  assign store_enable_out = w_main_se & w_out_valid;
  assign load_enable_out  = w_main_le & w_out_valid;

  assign out_valid = w_out_valid;
  assign in_ready  = w_in_ready;
  assign occupancy = {1'b0, r_state[1]} + {1'b0, r_state[0]};

endmodule
